seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multi-cycle restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
//  It is the inverse-direction counterpart of the datapath `adder`: it instantiates adder #(SIZE+1) as its subtractor.
//  Subtraction is done as X + ~Y with Cin=1; Cout=1 means no borrow.
//  Sits beside the ALU; the control unit stalls the pipeline while busy=1.
// PARAMETERS
//  SIZE  32  operand/result width in bits; must be >= 2
// PORTS
//  clk        in   1     single clock, all state on rising edge
//  rst        in   1     synchronous reset, active-high
//  start      in   1     request; sampled only in IDLE
//  is_signed  in   1     1: DIV/REM semantics, 0: DIVU/REMU semantics
//  dividend   in   SIZE  captured on accepted start
//  divisor    in   SIZE  captured on accepted start
//  busy       out  1     high while an operation is in flight (CALC/FIX)
//  done       out  1     one-cycle pulse; results are valid from this cycle on
//  quotient   out  SIZE  held until next accepted start
//  remainder  out  SIZE  held until next accepted start
//  div_zero   out  1     divisor was 0 for the last result; held with results
// BEHAVIOUR
//  - Reset: state=IDLE. busy, done, div_zero, quotient and remainder are all 0.
//  - Reset mid-operation aborts the operation: no done pulse, outputs go to their reset values.
//  - FSM states:
//    IDLE -start-> CALC
//    CALC -(count==SIZE-1)-> FIX
//    FIX -> IDLE, with done=1
//  - Accept: start=1 in IDLE at edge E0. At E0:
//    latch |dividend| and |divisor| (magnitudes if is_signed, else raw);
//    latch sign_q = sgn(a)^sgn(b) and sign_r = sgn(a);
//    clear the SIZE+1-bit partial remainder; count=0; busy=1.
//  - CALC, edges E1..E_SIZE, one quotient bit per edge, MSB first:
//    trial = {rem[SIZE-1:0], a_msb} - {1'b0, |divisor|};
//    if no borrow, rem=trial and qbit=1; else rem=shifted value and qbit=0.
//  - FIX, edge E_SIZE+1:
//    apply sign: quotient negated if sign_q, remainder negated if sign_r;
//    done=1, busy=0, state=IDLE.
//    Latency: start edge to done is SIZE+1 edges.
//  - Divide by zero (RISC-V rule, both signednesses):
//    quotient=all ones, remainder=dividend, div_zero=1.
//    For signed, the sign fix-up is suppressed.
//  - Signed overflow (most negative / -1): quotient=most negative, remainder=0.
//    This falls out of the magnitude arithmetic with no special case.
//  - start while busy=1: ignored, with no effect on the in-flight op.
//  - start in the done cycle: accepted, because the state is already IDLE.
//    busy rises and done drops on the next edge.
//  - Operand inputs are don't-care except at the accept edge.
// CONFIGURATION
//  DIV_ZERO_FAST_EN defined:
//    a zero divisor at accept goes IDLE->FIX directly, skipping CALC;
//    done follows at E1 (latency 1 edge).
//  DIV_ZERO_FAST_EN undefined:
//    a zero divisor runs the full SIZE iterations; latency is SIZE+1.
//  Result values are identical in both builds.
// TESTING (SIZE=32)
//  1. DIVU 100/7:
//     -> quotient=14, remainder=2, div_zero=0.
//     done exactly 33 edges after start; busy high for 33 cycles.
//  2. DIV 0xFFFFFFF9 (-7) / 2:
//     -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
//  3. DIV 0x80000000 / 0xFFFFFFFF:
//     -> quotient=0x80000000, remainder=0, div_zero=0.
//  4. DIVU and DIV 0x12345678/0:
//     -> quotient=0xFFFFFFFF, remainder=0x12345678, div_zero=1.
//     done after 1 edge with DIV_ZERO_FAST_EN, after 33 edges without.
//  5. Abort: start 1000/3, assert rst at edge 10 of CALC:
//     -> next cycle busy=0, done=0, outputs 0, and no done ever follows.
//     Then DIVU 9/3 gives quotient=3, remainder=0.
//  6. Back-to-back requests:
//     start held high through an op (A=50/5, then B=7/2 applied mid-op) is ignored mid-op;
//     start=1 with B in the done cycle of A is accepted;
//     B completes 33 edges later with quotient=3, remainder=1.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock, MSB first, on operand magnitudes. A sign
// fix-up state follows, and then a one-cycle done pulse.
// Optional build macro: DIV_ZERO_FAST_EN. When it is defined, a zero divisor
// skips the iteration and the result is ready one edge after accept.
// Contains the ripple `adder` that the divider uses as its subtractor.

module adder #(
  parameter int SIZE = 33
) (
  input  logic [SIZE-1:0] i_x,
  input  logic [SIZE-1:0] i_y,
  input  logic            i_cin,
  output logic [SIZE-1:0] o_sum,
  output logic            o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_x} + {1'b0, i_y} + {{SIZE{1'b0}}, i_cin};
endmodule

module seq_divider #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_signed,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder,
  output logic            div_zero
);

  localparam int              CW     = (SIZE > 2) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0]   L_LAST = CW'(SIZE - 1);
  localparam logic [SIZE-1:0] L_ONE  = SIZE'(1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t          r_state, w_next;
  logic [SIZE-1:0] r_a;          // dividend magnitude, shifts into quotient
  logic [SIZE-1:0] r_b;          // divisor magnitude
  logic [SIZE:0]   r_rem;        // partial remainder
  logic [CW-1:0]   r_count;
  logic            r_sign_q, r_sign_r, r_dz;
  logic            r_done, r_div_zero;
  logic [SIZE-1:0] r_quotient, r_remainder;

  logic            w_accept, w_a_neg, w_b_neg, w_b_zero;
  logic [SIZE-1:0] w_a_abs, w_b_abs;
  logic [SIZE:0]   w_shift, w_trial;
  logic            w_cout;
  logic [SIZE-1:0] w_q_mag, w_r_mag, w_q_final, w_r_final;
  logic            w_unused_rem_msb;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_a_neg  = is_signed & dividend[SIZE-1];
  assign w_b_neg  = is_signed & divisor[SIZE-1];
  assign w_a_abs  = w_a_neg ? (~dividend + L_ONE) : dividend;
  assign w_b_abs  = w_b_neg ? (~divisor + L_ONE) : divisor;
  assign w_b_zero = (divisor == '0);

  // The remainder always stays below the divisor, so its top bit never feeds the next shift.
  assign w_shift          = {r_rem[SIZE-1:0], r_a[SIZE-1]};
  assign w_unused_rem_msb = r_rem[SIZE];

  // Trial subtraction as shift + ~{0,b} + 1; carry out means no borrow.
  adder #(.SIZE(SIZE + 1)) u_sub (
    .i_x    (w_shift),
    .i_y    (~{1'b0, r_b}),
    .i_cin  (1'b1),
    .o_sum  (w_trial),
    .o_cout (w_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no path through this block can infer a latch.
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_FAST_EN
          w_next = w_b_zero ? S_FIX : S_CALC;
`else
          w_next = S_CALC;
`endif
        end
      end
      S_CALC:  if (r_count == L_LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // Sign fix-up. Divide-by-zero keeps the all-ones quotient unsigned, and
  // negating |a| restores the original dividend as the remainder.
  always_comb begin
    w_q_mag = r_a;
    w_r_mag = r_rem[SIZE-1:0];
`ifdef DIV_ZERO_FAST_EN
    // The fast path never iterated, so r_a still holds |dividend|.
    if (r_dz) begin
      w_q_mag = '1;
      w_r_mag = r_a;
    end
`endif
    w_q_final = (r_sign_q && !r_dz) ? (~w_q_mag + L_ONE) : w_q_mag;
    w_r_final = r_sign_r ? (~w_r_mag + L_ONE) : w_r_mag;
  end

  // Datapath: capture at accept, iterate in CALC, publish results in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_rem       <= '0;
      r_count     <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_dz        <= 1'b0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a      <= w_a_abs;
            r_b      <= w_b_abs;
            r_sign_q <= w_a_neg ^ w_b_neg;
            r_sign_r <= w_a_neg;
            r_dz     <= w_b_zero;
            r_rem    <= '0;
            r_count  <= '0;
          end
        end
        S_CALC: begin
          r_rem   <= w_cout ? w_trial : w_shift;
          r_a     <= {r_a[SIZE-2:0], w_cout};
          r_count <= r_count + CW'(1);
        end
        S_FIX: begin
          r_quotient  <= w_q_final;
          r_remainder <= w_r_final;
          r_div_zero  <= r_dz;
          r_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed test of seq_divider (SIZE=32) using hand-computed results.
// The expected zero-divisor latency follows the DIV_ZERO_FAST_EN build macro.

module tb_seq_divider;

  localparam int SIZE = 32;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            is_signed = 1'b0;
  logic [SIZE-1:0] dividend = '0;
  logic [SIZE-1:0] divisor = '0;
  logic            busy, done, div_zero;
  logic [SIZE-1:0] quotient, remainder;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_divider #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  // Drive a request and step past its accept edge. If hold is 0, start drops after that edge.
  task automatic launch(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input logic sg, input logic hold);
    @(negedge clk);
    start = 1'b1; is_signed = sg; dividend = a; divisor = b;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  // Count edges from the accept edge until done. A cycle budget bounds the wait; a timeout gives lat=-1.
  task automatic wait_done(output int lat, output int busy_cyc);
    lat = 0;
    busy_cyc = busy ? 1 : 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (busy) busy_cyc++;
      if (lat >= 200) begin lat = -1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (quotient !== '0) begin bad++; $display("FAIL reset_q got=%h exp=0", quotient); end
    total++; if (remainder !== '0) begin bad++; $display("FAIL reset_r got=%h exp=0", remainder); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_divu();
    int lat, bc;
    launch(32'd100, 32'd7, 1'b0, 1'b0);
    wait_done(lat, bc);
    total++; if (lat !== 33) begin bad++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    total++; if (bc !== 33) begin bad++; $display("FAIL divu_busy_cycles got=%0d exp=33", bc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL divu_busy_at_done got=%b exp=0", busy); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL divu_q got=%h exp=%h", quotient, 32'd14); end
    total++; if (remainder !== 32'd2) begin bad++; $display("FAIL divu_r got=%h exp=%h", remainder, 32'd2); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL divu_dz got=%b exp=0", div_zero); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL divu_done_pulse got=%b exp=0", done); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL divu_q_held got=%h exp=%h", quotient, 32'd14); end
  endtask

  task automatic test_signed();
    int lat, bc;
    launch(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    wait_done(lat, bc);
    total++; if (lat !== 33) begin bad++; $display("FAIL div_neg_latency got=%0d exp=33", lat); end
    total++; if (quotient !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_q got=%h exp=FFFFFFFD", quotient); end
    total++; if (remainder !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg_r got=%h exp=FFFFFFFF", remainder); end
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_done(lat, bc);
    total++; if (quotient !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_q got=%h exp=80000000", quotient); end
    total++; if (remainder !== 32'h0) begin bad++; $display("FAIL div_ovf_r got=%h exp=0", remainder); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL div_ovf_dz got=%b exp=0", div_zero); end
    // Same operand bits, unsigned: 0x80000000 / 0xFFFFFFFF = 0 remainder 0x80000000.
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_done(lat, bc);
    total++; if (quotient !== 32'h0) begin bad++; $display("FAIL divu_big_q got=%h exp=0", quotient); end
    total++; if (remainder !== 32'h8000_0000) begin bad++; $display("FAIL divu_big_r got=%h exp=80000000", remainder); end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    for (int sg = 0; sg < 2; sg++) begin
      launch(32'h1234_5678, 32'h0, sg[0], 1'b0);
      wait_done(lat, bc);
      total++; if (lat !== ZLAT) begin bad++; $display("FAIL dz_latency s=%0d got=%0d exp=%0d", sg, lat, ZLAT); end
      total++; if (quotient !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_q s=%0d got=%h exp=FFFFFFFF", sg, quotient); end
      total++; if (remainder !== 32'h1234_5678) begin bad++; $display("FAIL dz_r s=%0d got=%h exp=12345678", sg, remainder); end
      total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag s=%0d got=%b exp=1", sg, div_zero); end
    end
    // A negative dividend over zero must come back unchanged, with the quotient still all ones.
    launch(32'hFFFF_FFF9, 32'h0, 1'b1, 1'b0);
    wait_done(lat, bc);
    total++; if (quotient !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_neg_q got=%h exp=FFFFFFFF", quotient); end
    total++; if (remainder !== 32'hFFFF_FFF9) begin bad++; $display("FAIL dz_neg_r got=%h exp=FFFFFFF9", remainder); end
    // A nonzero divisor afterwards must clear the flag.
    launch(32'd9, 32'd4, 1'b0, 1'b0);
    wait_done(lat, bc);
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL dz_clear got=%b exp=0", div_zero); end
    total++; if (quotient !== 32'd2 || remainder !== 32'd1) begin
      bad++; $display("FAIL divu_9_4 got q=%h r=%h exp q=2 r=1", quotient, remainder);
    end
  endtask

  task automatic test_abort();
    int lat, bc, dones;
    launch(32'd1000, 32'd3, 1'b0, 1'b0);   // accept edge E0
    repeat (9) @(posedge clk);             // CALC edges E1..E9
    @(negedge clk); rst = 1'b1;            // sampled at E10
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
    total++; if (quotient !== '0 || remainder !== '0 || div_zero !== 1'b0) begin
      bad++; $display("FAIL abort_outputs got q=%h r=%h dz=%b exp all 0", quotient, remainder, div_zero);
    end
    @(negedge clk); rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    launch(32'd9, 32'd3, 1'b0, 1'b0);
    wait_done(lat, bc);
    total++; if (quotient !== 32'd3 || remainder !== 32'd0) begin
      bad++; $display("FAIL after_abort got q=%h r=%h exp q=3 r=0", quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    launch(32'd50, 32'd5, 1'b0, 1'b1);     // A accepted, start stays high
    @(negedge clk); dividend = 32'd7; divisor = 32'd2;
    wait_done(lat, bc);
    total++; if (lat !== 33) begin bad++; $display("FAIL b2b_a_latency got=%0d exp=33", lat); end
    total++; if (quotient !== 32'd10 || remainder !== 32'd0) begin
      bad++; $display("FAIL b2b_a got q=%h r=%h exp q=a r=0", quotient, remainder);
    end
    @(posedge clk); #1;                    // B accepted on the edge after done
    total++; if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_accept got busy=%b done=%b exp busy=1 done=0", busy, done);
    end
    start = 1'b0;
    wait_done(lat, bc);
    total++; if (lat !== 33) begin bad++; $display("FAIL b2b_b_latency got=%0d exp=33", lat); end
    total++; if (quotient !== 32'd3 || remainder !== 32'd1) begin
      bad++; $display("FAIL b2b_b got q=%h r=%h exp q=3 r=1", quotient, remainder);
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
